soc_reset_ctrl: RTL

Reset sequencer for the `picorv32_wb_soc` core domain. It merges three reset sources into one clean, stretched, glitch-free `soc_rst_o` that drives the core's `wb_rst` input, clocked by `wb_clk`:

- the HPS PIO reset request;
- the debounced KEY reset;
- an optional watchdog.

It also records the cause of the last reset and counts resets, so the HPS can read them back over PIO.

---
 rtl/soc_reset_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/soc_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : soc_reset_ctrl
// Purpose  : Merges HPS, KEY and optional watchdog (SOC_RESET_CTRL_WDT_EN)
//            resets into one stretched reset; records cause and count.
// Revision : 1.0
// ============================================================================
module soc_reset_ctrl #(
    parameter int HOLD_CYCLES = 1024,
    parameter int WDT_TIMEOUT = 24000000,
    parameter int WDT_W       = 25
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       hps_rst_req_i,
    input  logic       key_rst_n_i,
    input  logic       wdt_kick_i,
    output logic       soc_rst_o,
    output logic [3:0] rst_cause_o,
    output logic [7:0] rst_count_o
);

    localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_WAIT_REL = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_soc_rst;
    logic [3:0]       r_cause;
    logic [7:0]       r_count;
    logic             r_hps_meta, r_hps_s;
    logic             r_key_meta, r_key_n_s;
    logic             w_wdt_fire;
    logic             w_req;

    // Synchronisers come out of reset at the inactive level of each source
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_hps_meta <= 1'b0;
            r_hps_s    <= 1'b0;
            r_key_meta <= 1'b1;
            r_key_n_s  <= 1'b1;
        end else begin
            r_hps_meta <= hps_rst_req_i;
            r_hps_s    <= r_hps_meta;
            r_key_meta <= key_rst_n_i;
            r_key_n_s  <= r_key_meta;
        end
    end

`ifdef SOC_RESET_CTRL_WDT_EN
    localparam logic [WDT_W-1:0] c_wdt_last = WDT_W'(WDT_TIMEOUT - 1);
    logic [WDT_W-1:0] r_wdt_cnt;

    // A kick on the terminal-count cycle suppresses the fire
    assign w_wdt_fire = (r_state == S_RUN) && (r_wdt_cnt == c_wdt_last) && !wdt_kick_i;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_wdt_cnt <= '0;
        end else if ((r_state != S_RUN) || wdt_kick_i || w_wdt_fire) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_wdt_fire = 1'b0;
    assign w_unused   = wdt_kick_i & (WDT_TIMEOUT > 0) & (WDT_W > 0);
`endif

    assign w_req = r_hps_s | ~r_key_n_s | w_wdt_fire;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state   <= S_HOLD;
            r_cnt     <= c_hold_load;
            r_soc_rst <= 1'b1;
            r_cause   <= 4'b0001;
            r_count   <= 8'd0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_soc_rst <= 1'b1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_req) begin
                        r_state <= S_WAIT_REL;
                    end else begin
                        r_state   <= S_RUN;
                        r_soc_rst <= 1'b0;
                    end
                end
                S_WAIT_REL: begin
                    if (!w_req) begin
                        r_state   <= S_RUN;
                        r_soc_rst <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_req) begin
                        r_state   <= S_HOLD;
                        r_cnt     <= c_hold_load;
                        r_soc_rst <= 1'b1;
                        r_cause   <= {w_wdt_fire, ~r_key_n_s, r_hps_s, 1'b0};
                        if (r_count != 8'hFF) begin
                            r_count <= r_count + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_HOLD;
                    r_cnt     <= c_hold_load;
                    r_soc_rst <= 1'b1;
                end
            endcase
        end
    end

    assign soc_rst_o   = r_soc_rst;
    assign rst_cause_o = r_cause;
    assign rst_count_o = r_count;

endmodule
`default_nettype wire
